uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk_i cycles per bit (100 MHz / 115200 baud); legal range >= 8.
REQ-002 SHALL have port clk_i  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port nreset_i  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data_o  output  8  received byte, held stable while valid is high.
REQ-006 SHALL have port valid  output  1  rx_data_o holds an unconsumed byte.
REQ-007 SHALL have port ready  input  1  consumer accepts the byte when ready && valid.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse: a byte completed while the holding register was still full.

Function
REQ-010 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: on rx_s == 0, SHALL clear the bit-timer and go to START.
REQ-013 START: after CLKS_PER_BIT/2 cycles, SHALL sample rx_s; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, no outputs).
REQ-014 DATA: every CLKS_PER_BIT cycles, SHALL sample rx_s into the shift register, LSB first; after the 8th sample -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles, SHALL sample rx_s; 1 -> deliver byte and go to IDLE; 0 -> pulse frame_err_o, discard byte, go to BREAK.
REQ-016 BREAK: SHALL remain until rx_s == 1, then go to IDLE; no new frame is detected while in BREAK.
REQ-017 Delivery: valid and rx_data_o SHALL update in the cycle after the stop-bit sample. Latency from the rx_i start edge to valid is approximately 9.5*CLKS_PER_BIT + 3 cycles.
REQ-018 Handshake: valid SHALL stay high and rx_data_o SHALL stay constant until a cycle with ready == 1; valid drops in the following cycle.
REQ-019 Delivery with valid == 1 and no handshake in the same cycle: SHALL keep the old byte, drop the new byte, and pulse overrun_o.
REQ-020 Delivery in the same cycle as a ready && valid handshake: SHALL load the new byte, keep valid high, and raise no overrun.
REQ-021 The bit-timer SHALL be sized as clog2(CLKS_PER_BIT) bits and SHALL wrap to 0 at CLKS_PER_BIT-1. The bit counter is 3 bits.
REQ-022 ready while valid == 0 SHALL have no effect.

Reset
REQ-023 With nreset_i == 0 at a clock edge, the following SHALL hold next cycle: state IDLE, rx_data_o = 8'h00, valid = 0, frame_err_o = 0, overrun_o = 0, timers and counters 0, synchronizer flops = 1.
REQ-024 Reset mid-frame SHALL abandon the frame with no outputs. After release, the receiver SHALL resynchronise on the next falling edge seen from IDLE.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state encoding, DATA_BITS = 8, and default CLKS_PER_BIT = 868, common with uart_tx.
REQ-026 One sub-module uart_baud_timer (counter with clear input, half-period and full-period tick outputs) SHALL be instantiated. All other logic stays in uart_rx.

Verification
REQ-027 Frame 0x95 at 868 clk/bit, ready = 1 -> exactly one valid cycle with rx_data_o = 8'h95, no error pulses.
REQ-028 rx_i low for 200 cycles then high -> no valid, no frame_err_o, FSM back in IDLE. A following 0x14 frame -> rx_data_o = 8'h14.
REQ-029 Frame 0xA5 with stop bit driven 0, line held low 3000 cycles -> one frame_err_o pulse, valid stays 0. After the line returns high, 0x3C is received correctly.
REQ-030 ready = 0, frames 0x95 then 0x14 -> valid with 8'h95 held, one overrun_o pulse at the second stop sample. Then ready = 1 -> 8'h95 consumed, valid = 0.
REQ-031 Back-to-back frames 0x01, 0x80, 0xFF with ready tied high -> three deliveries in order, no overrun. Also cover the same-cycle handshake and delivery case per REQ-020.
REQ-032 nreset_i = 0 for 1 cycle during bit 4 of 0x55 -> no valid for that frame. The next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver state encoding.
// The transmitter side uses the same constants.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream from the UART receiver to its consumer.
// valid/ready: a byte moves on every clock edge where valid && ready; once valid rises,
// the source holds valid and rx_data_o steady until that edge. ready has no effect while valid is low.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data_o;
    logic                 valid;
    logic                 ready;

    modport master (output rx_data_o, output valid, input ready);
    modport slave  (input rx_data_o, input valid, output ready);

endinterface

// File: rtl/uart_baud_timer.sv
// Free-running bit-period counter with synchronous clear.
// Produces strobes at the half-bit and full-bit points measured from the last clear.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic clr,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            cnt <= '0;
        end else if (clr || full_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign half_tick = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_i, samples each bit at its centre and hands bytes
// out over a valid/ready holding register, flagging framing errors and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       rx_i,
    uart_rx_if.master  stream,
    output logic       frame_err_o,
    output logic       overrun_o,
    output rx_state_t  state_dbg
);

    rx_state_t                state, state_next;
    logic [1:0]               sync;
    logic                     rx_s;
    logic [2:0]               bit_cnt;
    logic [DATA_BITS-1:0]     shift;
    logic [DATA_BITS-1:0]     rx_data;
    logic                     valid;
    logic                     timer_clr, half_tick, full_tick;
    logic                     sample_bit, deliver, frame_err_set;
    logic                     handshake, hold_full;

    assign rx_s      = sync[1];
    assign handshake = valid && stream.ready;
    // A full holding register that is not being drained this cycle cannot take a new byte.
    assign hold_full = valid && !stream.ready;

    uart_baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .clr       (timer_clr),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        timer_clr     = 1'b0;
        sample_bit    = 1'b0;
        deliver       = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (half_tick) begin
                    timer_clr  = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick) begin
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) state_next = STOP;
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rx_s) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = BREAK;
                    end
                end
            end
            BREAK: begin
                timer_clr = 1'b1;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            sync        <= 2'b11;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            valid       <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            sync        <= {sync[0], rx_i};
            frame_err_o <= frame_err_set;
            overrun_o   <= deliver && hold_full;
            if (sample_bit) begin
                shift   <= {rx_s, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (deliver && !hold_full) begin
                rx_data <= shift;
                valid   <= 1'b1;
            end else if (handshake) begin
                valid <= 1'b0;
            end
        end
    end

    assign stream.rx_data_o = rx_data;
    assign stream.valid     = valid;
    assign state_dbg        = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames bit by bit and checks delivered bytes against
// a queue of bytes the line carried, plus pulse counters for framing errors and overruns.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C           = 32;
    localparam int DELIVER_LAT = 9 * C + C / 2 + 3;
    localparam int GLITCH_LEN  = (200 * C) / 868;
    localparam int BREAK_HOLD  = (3000 * C) / 868;

    logic      clk = 1'b0;
    logic      nreset_i = 1'b0;
    logic      rx = 1'b1;
    logic      ready_man = 1'b0;
    logic      rand_mode = 1'b0;
    logic      rand_bit = 1'b0;
    logic      frame_err, overrun;
    rx_state_t state_dbg;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp, last_data;
    logic       last_hold = 1'b0;
    int         checks = 0, fails = 0;
    int         valid_cycles = 0, fe_cnt = 0, ov_cnt = 0;

    uart_rx_if rif ();
    assign rif.ready = rand_mode ? rand_bit : ready_man;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_i       (clk),
        .nreset_i    (nreset_i),
        .rx_i        (rx),
        .stream      (rif.master),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .state_dbg   (state_dbg)
    );

    // clock / reset-free stimulus helpers
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    // monitor + scoreboard
    always @(negedge clk) begin
        if (nreset_i) begin
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
            if (rif.valid === 1'b1) valid_cycles++;
            if (last_hold) begin
                checks++;
                if (rif.valid !== 1'b1 || rif.rx_data_o !== last_data) begin
                    fails++;
                    $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h", rif.valid, rif.rx_data_o, last_data);
                end
            end
            if (rif.valid === 1'b1 && rif.ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %h, none expected", rif.rx_data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rif.rx_data_o !== mon_exp) begin
                        fails++;
                        $display("FAIL byte: got %h, required %h", rif.rx_data_o, mon_exp);
                    end
                end
            end
            last_hold = (rif.valid === 1'b1) && (rif.ready !== 1'b1);
            last_data = rif.rx_data_o;
        end else begin
            last_hold = 1'b0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks (all drives happen 1 time unit after a rising edge)
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset_i = 1'b0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rif.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", rif.valid); end
        checks++; if (rif.rx_data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", rif.rx_data_o); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL reset_state: got %0d, required IDLE", state_dbg); end
        nreset_i = 1'b1;
        idle_cycles(10);
        checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL post_reset_idle: got %0d, required IDLE", state_dbg); end
    endtask

    task automatic test_single();
        int v0, f0, o0;
        ready_man = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h95);
        send_frame(8'h95, 1'b1);
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL single_delivered: %0d pending, required 0", exp_q.size()); end
        checks++; if (valid_cycles - v0 != 1) begin fails++; $display("FAIL single_valid_cycles: got %0d, required 1", valid_cycles - v0); end
        checks++; if (fe_cnt != f0 || ov_cnt != o0) begin fails++; $display("FAIL single_errors: fe=%0d ov=%0d, required 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        ready_man = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt;
        rx = 1'b0;
        repeat (GLITCH_LEN) @(posedge clk);
        #1;
        idle_cycles(2 * C);
        checks++; if (valid_cycles != v0) begin fails++; $display("FAIL glitch_valid: got %0d cycles, required 0", valid_cycles - v0); end
        checks++; if (fe_cnt != f0) begin fails++; $display("FAIL glitch_frame_err: got %0d, required 0", fe_cnt - f0); end
        checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL glitch_state: got %0d, required IDLE", state_dbg); end
        exp_q.push_back(8'h14);
        send_frame(8'h14, 1'b1);
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL glitch_next_frame: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_break();
        int v0, f0;
        ready_man = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt;
        send_frame(8'hA5, 1'b0);
        rx = 1'b0;
        repeat (BREAK_HOLD) @(posedge clk);
        #1;
        checks++; if (fe_cnt - f0 != 1) begin fails++; $display("FAIL break_frame_err: got %0d pulses, required 1", fe_cnt - f0); end
        checks++; if (valid_cycles != v0) begin fails++; $display("FAIL break_valid: got %0d cycles, required 0", valid_cycles - v0); end
        checks++; if (state_dbg !== BREAK) begin fails++; $display("FAIL break_state: got %0d, required BREAK", state_dbg); end
        idle_cycles(2 * C);
        checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL break_exit: got %0d, required IDLE", state_dbg); end
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL break_recovery: %0d pending, required 0", exp_q.size()); end
        checks++; if (fe_cnt - f0 != 1) begin fails++; $display("FAIL break_extra_err: got %0d pulses, required 1", fe_cnt - f0); end
    endtask

    task automatic test_overrun();
        int o0;
        ready_man = 1'b0;
        o0 = ov_cnt;
        exp_q.push_back(8'h95);
        send_frame(8'h95, 1'b1);
        send_frame(8'h14, 1'b1);
        idle_cycles(4);
        checks++; if (ov_cnt - o0 != 1) begin fails++; $display("FAIL overrun_pulse: got %0d, required 1", ov_cnt - o0); end
        checks++; if (rif.valid !== 1'b1) begin fails++; $display("FAIL overrun_valid: got %b, required 1", rif.valid); end
        checks++; if (rif.rx_data_o !== 8'h95) begin fails++; $display("FAIL overrun_data: got %h, required 95", rif.rx_data_o); end
        ready_man = 1'b1;
        idle_cycles(3);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL overrun_consume: %0d pending, required 0", exp_q.size()); end
        checks++; if (rif.valid !== 1'b0) begin fails++; $display("FAIL overrun_drain: valid=%b, required 0", rif.valid); end
    endtask

    task automatic test_back_to_back();
        int o0, f0;
        ready_man = 1'b1;
        o0 = ov_cnt; f0 = fe_cnt;
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        send_frame(8'h01, 1'b1);
        send_frame(8'h80, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_delivered: %0d pending, required 0", exp_q.size()); end
        checks++; if (ov_cnt != o0 || fe_cnt != f0) begin fails++; $display("FAIL b2b_errors: ov=%0d fe=%0d, required 0 0", ov_cnt - o0, fe_cnt - f0); end
    endtask

    task automatic test_same_cycle();
        int o0;
        ready_man = 1'b0;
        o0 = ov_cnt;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        idle_cycles(C);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (DELIVER_LAT - 1) @(posedge clk);
                #1 ready_man = 1'b1;
                @(posedge clk);
                #1 ready_man = 1'b0;
            end
        join
        idle_cycles(4);
        checks++; if (exp_q.size() != 1) begin fails++; $display("FAIL same_cycle_pending: %0d pending, required 1", exp_q.size()); end
        checks++; if (rif.valid !== 1'b1) begin fails++; $display("FAIL same_cycle_valid: got %b, required 1", rif.valid); end
        checks++; if (rif.rx_data_o !== 8'h22) begin fails++; $display("FAIL same_cycle_data: got %h, required 22", rif.rx_data_o); end
        checks++; if (ov_cnt != o0) begin fails++; $display("FAIL same_cycle_overrun: got %0d, required 0", ov_cnt - o0); end
        ready_man = 1'b1;
        idle_cycles(3);
        checks++; if (exp_q.size() != 0 || rif.valid !== 1'b0) begin fails++; $display("FAIL same_cycle_drain: pending=%0d valid=%b, required 0 0", exp_q.size(), rif.valid); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        logic [7:0] b;
        ready_man = 1'b1;
        v0 = valid_cycles; f0 = fe_cnt;
        b = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (C / 2) @(posedge clk);
        #1 nreset_i = 1'b0;
        @(posedge clk);
        #1 nreset_i = 1'b1;
        idle_cycles(12 * C);
        checks++; if (valid_cycles != v0) begin fails++; $display("FAIL midreset_valid: got %0d cycles, required 0", valid_cycles - v0); end
        checks++; if (fe_cnt != f0) begin fails++; $display("FAIL midreset_frame_err: got %0d, required 0", fe_cnt - f0); end
        checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL midreset_state: got %0d, required IDLE", state_dbg); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL midreset_next_frame: %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        int o0, f0, gap;
        logic [7:0] b;
        o0 = ov_cnt; f0 = fe_cnt;
        ready_man = 1'b1;
        rand_mode = 1'b1;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2 * C));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle_cycles(gap);
        end
        idle_cycles(4 * C);
        rand_mode = 1'b0;
        idle_cycles(4);
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL random_delivered: %0d pending, required 0", exp_q.size()); end
        checks++; if (ov_cnt != o0 || fe_cnt != f0) begin fails++; $display("FAIL random_errors: ov=%0d fe=%0d, required 0 0", ov_cnt - o0, fe_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_overrun();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
